// File: rtl/boot_loader_pkg.sv
// Shared definitions for the boot loader: FSM encoding, default load base and
// the memory byte-enable helper.
package boot_loader_pkg;

    typedef enum logic [2:0] {
        ST_LEN   = 3'd0,
        ST_DATA  = 3'd1,
        ST_CSUM  = 3'd2,
        ST_RUN   = 3'd3,
        ST_ERROR = 3'd4
    } state_e;

    // Must match the core reset vector so the loaded image is what the core fetches.
    localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;

    function automatic logic [3:0] byte_en(input logic we);
        return we ? 4'hF : 4'h0;
    endfunction

endpackage

// File: rtl/boot_loader_byte_assembler.sv
// Collects four host bytes, least significant first, into one 32-bit word and
// flags the edge on which the fourth byte is accepted.
module boot_loader_byte_assembler
    import boot_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  byte_i,
    input  logic        valid_i,
    output logic [31:0] word_o,
    output logic        word_valid_o
);

    logic [1:0]  idx_q;
    logic [1:0]  idx_d;
    logic [23:0] shift_q;
    logic [23:0] shift_d;

    // Newest byte enters at the top so byte 0 ends up in bits [7:0].
    always_comb begin
        idx_d   = idx_q;
        shift_d = shift_q;
        if (valid_i) begin
            idx_d   = idx_q + 2'd1;
            shift_d = {byte_i, shift_q[23:8]};
        end else begin
            idx_d   = idx_q;
            shift_d = shift_q;
        end
    end

    // Byte index and partial-word register.
    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q   <= 2'd0;
            shift_q <= 24'd0;
        end else begin
            idx_q   <= idx_d;
            shift_q <= shift_d;
        end
    end

    assign word_o       = {byte_i, shift_q};
    assign word_valid_o = valid_i && (idx_q == 2'd3);

endmodule

// File: rtl/boot_loader.sv
// Holds the core in reset while a length/payload/checksum image streams in,
// writes payload words to memory and releases the core only on a valid image.
module boot_loader
    import boot_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = RESET_VECTOR,
    parameter int unsigned MAX_WORDS = 1024,
    parameter int unsigned CNT_W     = 11
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_di,
    output logic [3:0]  mem_be,
    output logic        core_resetb,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e             state_q;
    state_e             state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   len_q;
    logic [31:0]        csum_q;
    logic               mem_we_q;
    logic [31:0]        mem_addr_q;
    logic [31:0]        mem_di_q;
    logic               accept_s;
    logic [31:0]        word_s;
    logic               word_valid_s;
    logic               last_word_s;

    assign accept_s    = in_valid && in_ready;
    assign last_word_s = ((cnt_q + CNT_ONE) == len_q);

    boot_loader_byte_assembler u_asm (
        .clk          (clk),
        .reset        (reset),
        .byte_i       (in_data),
        .valid_i      (accept_s),
        .word_o       (word_s),
        .word_valid_o (word_valid_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_LEN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decision, taken only on a completed word.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_LEN: begin
                if (!word_valid_s)                  state_d = ST_LEN;
                else if (word_s > 32'(MAX_WORDS))   state_d = ST_ERROR;
                else if (word_s == 32'd0)           state_d = ST_CSUM;
                else                                state_d = ST_DATA;
            end
            ST_DATA: begin
                if (word_valid_s && last_word_s)    state_d = ST_CSUM;
                else                                state_d = ST_DATA;
            end
            ST_CSUM: begin
                if (!word_valid_s)                  state_d = ST_CSUM;
                else if (word_s == csum_q)          state_d = ST_RUN;
                else                                state_d = ST_ERROR;
            end
            ST_RUN:   state_d = ST_RUN;
            ST_ERROR: state_d = ST_ERROR;
            default:  state_d = ST_ERROR;
        endcase
    end

    // Status outputs decode the registered state, so they change one cycle after the deciding byte.
    always_comb begin
        in_ready    = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        err         = 1'b0;
        core_resetb = 1'b0;
        case (state_q)
            ST_LEN, ST_DATA, ST_CSUM: begin
                in_ready = 1'b1;
                busy     = 1'b1;
            end
            ST_RUN: begin
                done        = 1'b1;
                core_resetb = 1'b1;
            end
            ST_ERROR: err = 1'b1;
            default:  err = 1'b1;
        endcase
        mem_we   = mem_we_q;
        mem_addr = mem_addr_q;
        mem_di   = mem_di_q;
        mem_be   = byte_en(mem_we_q);
    end

    // Length, word counter, running checksum and the registered write port.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q      <= '0;
            len_q      <= '0;
            csum_q     <= 32'd0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= BASE_ADDR;
            mem_di_q   <= 32'd0;
        end else begin
            mem_we_q <= 1'b0;
            if (word_valid_s && (state_q == ST_LEN)) begin
                len_q  <= word_s[CNT_W-1:0];
                cnt_q  <= '0;
                csum_q <= 32'd0;
            end else if (word_valid_s && (state_q == ST_DATA)) begin
                mem_we_q   <= 1'b1;
                mem_addr_q <= BASE_ADDR + (32'(cnt_q) << 2'd2);
                mem_di_q   <= word_s;
                csum_q     <= csum_q ^ word_s;
                cnt_q      <= cnt_q + CNT_ONE;
            end else begin
                cnt_q <= cnt_q;
            end
        end
    end

endmodule
